// File: rtl/receiver_data_arbiter_pkg.sv
// Shared widths and record layout for decoded receiver words.
// Also used by single_receiver_manager and the downstream solver interface.
package receiver_data_arbiter_pkg;

  localparam int unsigned SENSOR_DATA_W = 17;
  localparam int unsigned SENSOR_TS_W   = 24;
  localparam int unsigned SENSOR_ID_W   = 2;

  // One merged word as seen by the solver side
  typedef struct packed {
    logic [SENSOR_ID_W-1:0]   id;
    logic [SENSOR_DATA_W-1:0] data;
    logic [SENSOR_TS_W-1:0]   ts;
  } sensor_record_t;

  localparam int unsigned SENSOR_RECORD_W = $bits(sensor_record_t);

endpackage

// File: rtl/receiver_data_arbiter_rr_picker.sv
// Combinational round-robin picker: first request at or after the pointer, wrapping.
module rr_picker #(
  parameter int unsigned N    = 4,
  parameter int unsigned ID_W = 2
) (
  input  logic [N-1:0]    req,
  input  logic [ID_W-1:0] ptr,
  output logic [N-1:0]    grant,
  output logic [ID_W-1:0] idx,
  output logic            any_grant
);

  always_comb begin
    int unsigned cand;
    grant     = '0;
    idx       = '0;
    any_grant = 1'b0;
    cand      = 0;
    for (int unsigned k = 0; k < N; k++) begin
      // Explicit wrap so unused pointer codes are never produced
      cand = 32'(ptr) + k;
      if (cand >= N) cand = cand - N;
      if (!any_grant && req[cand]) begin
        any_grant   = 1'b1;
        idx         = ID_W'(cand);
        grant[cand] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/receiver_data_arbiter.sv
// Merges N receiver data streams through one-entry slots and a round-robin picker
// into a single registered valid/ready output, with per-receiver drop accounting.
module receiver_data_arbiter
  import receiver_data_arbiter_pkg::*;
#(
  parameter int unsigned N_SENSORS = 4,
  parameter int unsigned DATA_W    = SENSOR_DATA_W,
  parameter int unsigned TS_W      = SENSOR_TS_W,
  parameter int unsigned ID_W      = SENSOR_ID_W,
  parameter int unsigned DROP_W    = 8
) (
  input  logic                          clk_96MHz,
  input  logic                          reset,
  input  logic [N_SENSORS-1:0]          data_availible,
  input  logic [N_SENSORS*DATA_W-1:0]   decoded_data,
  input  logic [N_SENSORS*TS_W-1:0]     timestamp_last_data,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [ID_W-1:0]               out_sensor_id,
  output logic [DATA_W-1:0]             out_data,
  output logic [TS_W-1:0]               out_timestamp,
  output logic [N_SENSORS-1:0]          drop_sticky,
  output logic [N_SENSORS*DROP_W-1:0]   drop_count
);

  logic [N_SENSORS-1:0]             slot_full;
  logic [DATA_W-1:0]                slot_data [N_SENSORS];
  logic [TS_W-1:0]                  slot_ts   [N_SENSORS];
  logic [N_SENSORS-1:0][DROP_W-1:0] drop_cnt;
  logic [ID_W-1:0]                  rr_ptr;

  logic [N_SENSORS-1:0] pick_onehot_c;
  logic [ID_W-1:0]      pick_idx_c;
  logic                 pick_any_c;
  logic                 out_free_c;
  logic                 grant_en_c;
  logic [N_SENSORS-1:0] grant_c;

  rr_picker #(
    .N    (N_SENSORS),
    .ID_W (ID_W)
  ) u_rr_picker (
    .req       (slot_full),
    .ptr       (rr_ptr),
    .grant     (pick_onehot_c),
    .idx       (pick_idx_c),
    .any_grant (pick_any_c)
  );

  assign out_free_c = !out_valid || out_ready;
  assign grant_en_c = out_free_c && pick_any_c;
  assign grant_c    = grant_en_c ? pick_onehot_c : '0;
  assign drop_count = drop_cnt;

  // Slot capture/drain and drop accounting
  always_ff @(posedge clk_96MHz) begin
    if (reset) begin
      slot_full   <= '0;
      drop_sticky <= '0;
      drop_cnt    <= '0;
      for (int unsigned i = 0; i < N_SENSORS; i++) begin
        slot_data[i] <= '0;
        slot_ts[i]   <= '0;
      end
    end else begin
      for (int unsigned i = 0; i < N_SENSORS; i++) begin
        if (data_availible[i]) begin
          // A slot being granted this cycle can take the new word without loss
          if (!slot_full[i] || grant_c[i]) begin
            slot_full[i] <= 1'b1;
            slot_data[i] <= decoded_data[i*DATA_W +: DATA_W];
            slot_ts[i]   <= timestamp_last_data[i*TS_W +: TS_W];
          end else begin
            drop_sticky[i] <= 1'b1;
            if (drop_cnt[i] != {DROP_W{1'b1}}) drop_cnt[i] <= drop_cnt[i] + DROP_W'(1);
          end
        end else if (grant_c[i]) begin
          slot_full[i] <= 1'b0;
        end
      end
    end
  end

  // Output register and round-robin pointer
  always_ff @(posedge clk_96MHz) begin
    if (reset) begin
      out_valid     <= 1'b0;
      out_sensor_id <= '0;
      out_data      <= '0;
      out_timestamp <= '0;
      rr_ptr        <= '0;
    end else if (grant_en_c) begin
      out_valid     <= 1'b1;
      out_sensor_id <= pick_idx_c;
      out_data      <= slot_data[pick_idx_c];
      out_timestamp <= slot_ts[pick_idx_c];
      rr_ptr        <= (pick_idx_c == ID_W'(N_SENSORS - 1)) ? '0 : pick_idx_c + ID_W'(1);
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_receiver_data_arbiter.sv
// Self-checking bench for receiver_data_arbiter: directed scenarios plus randomized
// traffic compared against a queue-free behavioural model of slots, picker and counters.
module tb_receiver_data_arbiter;

  localparam int NS = 4;
  localparam int DW = 17;
  localparam int TW = 24;
  localparam int IW = 2;
  localparam int CW = 8;

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic [NS-1:0]   strb = '0;
  logic [NS*DW-1:0] dd = '0;
  logic [NS*TW-1:0] tt = '0;
  logic            out_ready = 1'b1;
  logic            out_valid;
  logic [IW-1:0]   out_sensor_id;
  logic [DW-1:0]   out_data;
  logic [TW-1:0]   out_timestamp;
  logic [NS-1:0]   drop_sticky;
  logic [NS*CW-1:0] drop_count;

  int n_tests = 0;
  int n_fail  = 0;

  // Behavioural model state
  bit      m_full [NS];
  int      m_data [NS];
  int      m_ts   [NS];
  int      m_cnt  [NS];
  bit      m_sticky [NS];
  int      m_ptr;
  bit      m_ov;
  int      m_id, m_od, m_ots;

  always #5 clk = ~clk;

  receiver_data_arbiter dut (
    .clk_96MHz           (clk),
    .reset               (reset),
    .data_availible      (strb),
    .decoded_data        (dd),
    .timestamp_last_data (tt),
    .out_valid           (out_valid),
    .out_ready           (out_ready),
    .out_sensor_id       (out_sensor_id),
    .out_data            (out_data),
    .out_timestamp       (out_timestamp),
    .drop_sticky         (drop_sticky),
    .drop_count          (drop_count)
  );

  task automatic set_word(input int i, input logic [DW-1:0] d, input logic [TW-1:0] t);
    dd[i*DW +: DW] = d;
    tt[i*TW +: TW] = t;
  endtask

  function automatic logic [CW-1:0] cnt_of(input int i);
    return drop_count[i*CW +: CW];
  endfunction

  // One clock: drive inputs, advance the model by the arbitration rules, sample #1 after the edge
  task automatic cycle(input logic [NS-1:0] s, input logic rdy, input logic rst);
    int g;
    bit old_full [NS];
    strb = s; out_ready = rdy; reset = rst;
    for (int i = 0; i < NS; i++) old_full[i] = m_full[i];
    g = -1;
    if (!m_ov || rdy) begin
      for (int k = 0; k < NS; k++)
        if (g < 0 && m_full[(m_ptr + k) % NS]) g = (m_ptr + k) % NS;
    end
    if (g >= 0) begin
      m_ov = 1; m_id = g; m_od = m_data[g]; m_ots = m_ts[g];
      m_ptr = (g + 1) % NS;
      m_full[g] = 0;
    end else if (rdy) begin
      m_ov = 0;
    end
    for (int i = 0; i < NS; i++) begin
      if (s[i]) begin
        if (old_full[i] && g != i) begin
          m_sticky[i] = 1;
          if (m_cnt[i] < 255) m_cnt[i]++;
        end else begin
          m_full[i] = 1;
          m_data[i] = int'(dd[i*DW +: DW]);
          m_ts[i]   = int'(tt[i*TW +: TW]);
        end
      end
    end
    if (rst) begin
      for (int i = 0; i < NS; i++) begin
        m_full[i] = 0; m_data[i] = 0; m_ts[i] = 0; m_cnt[i] = 0; m_sticky[i] = 0;
      end
      m_ptr = 0; m_ov = 0; m_id = 0; m_od = 0; m_ots = 0;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    cycle('0, 1'b1, 1'b1);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    apply_reset();
    n_tests++;
    if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", out_valid); end
    n_tests++;
    if ({out_sensor_id, out_data, out_timestamp} !== '0) begin
      n_fail++; $display("FAIL reset_out: got id=%0d data=%h ts=%h want 0", out_sensor_id, out_data, out_timestamp);
    end
    n_tests++;
    if (drop_sticky !== '0 || drop_count !== '0) begin
      n_fail++; $display("FAIL reset_drop: got sticky=%b count=%h want 0", drop_sticky, drop_count);
    end
  endtask

  task automatic test_single_word();
    apply_reset();
    set_word(2, 17'h1ABCD, 24'h123456);
    cycle(4'b0100, 1'b1, 1'b0);
    n_tests++;
    if (out_valid !== 1'b0) begin n_fail++; $display("FAIL single_t1_valid: got %b want 0", out_valid); end
    cycle('0, 1'b1, 1'b0);
    n_tests++;
    if (out_valid !== 1'b1 || out_sensor_id !== 2'd2 || out_data !== 17'h1ABCD || out_timestamp !== 24'h123456) begin
      n_fail++;
      $display("FAIL single_t2_word: got v=%b id=%0d data=%h ts=%h want v=1 id=2 data=1abcd ts=123456",
               out_valid, out_sensor_id, out_data, out_timestamp);
    end
    cycle('0, 1'b1, 1'b0);
    n_tests++;
    if (out_valid !== 1'b0) begin n_fail++; $display("FAIL single_t3_valid: got %b want 0", out_valid); end
  endtask

  task automatic test_fairness();
    apply_reset();
    for (int round = 0; round < 2; round++) begin
      for (int i = 0; i < NS; i++) set_word(i, DW'(17'h100 * (round + 1) + i), TW'(24'h5000 + i));
      cycle(4'b1111, 1'b1, 1'b0);
      for (int k = 0; k < NS; k++) begin
        cycle('0, 1'b1, 1'b0);
        n_tests++;
        if (out_valid !== 1'b1 || out_sensor_id !== IW'(k) || out_data !== DW'(17'h100 * (round + 1) + k)) begin
          n_fail++;
          $display("FAIL fair_r%0d_k%0d: got v=%b id=%0d data=%h want v=1 id=%0d data=%h",
                   round, k, out_valid, out_sensor_id, out_data, k, 17'h100 * (round + 1) + k);
        end
      end
      cycle('0, 1'b1, 1'b0);
      n_tests++;
      if (out_valid !== 1'b0) begin n_fail++; $display("FAIL fair_r%0d_idle: got %b want 0", round, out_valid); end
    end
  endtask

  task automatic test_backpressure();
    apply_reset();
    set_word(0, 17'h00AAA, 24'h000111);
    cycle(4'b0001, 1'b0, 1'b0);
    cycle('0, 1'b0, 1'b0);
    set_word(1, 17'h0BEEF, 24'h000222);
    cycle(4'b0010, 1'b0, 1'b0);
    set_word(1, 17'h0DEAD, 24'h000333);
    cycle(4'b0010, 1'b0, 1'b0);
    n_tests++;
    if (out_valid !== 1'b1 || out_sensor_id !== 2'd0 || out_data !== 17'h00AAA || out_timestamp !== 24'h000111) begin
      n_fail++; $display("FAIL bp_hold: got v=%b id=%0d data=%h ts=%h want v=1 id=0 data=00aaa ts=000111",
                         out_valid, out_sensor_id, out_data, out_timestamp);
    end
    n_tests++;
    if (drop_sticky !== 4'b0010 || cnt_of(1) !== 8'd1) begin
      n_fail++; $display("FAIL bp_drop: got sticky=%b cnt1=%0d want sticky=0010 cnt1=1", drop_sticky, cnt_of(1));
    end
    cycle('0, 1'b1, 1'b0);
    n_tests++;
    if (out_valid !== 1'b1 || out_sensor_id !== 2'd1 || out_data !== 17'h0BEEF) begin
      n_fail++; $display("FAIL bp_release: got v=%b id=%0d data=%h want v=1 id=1 data=0beef",
                         out_valid, out_sensor_id, out_data);
    end
    cycle('0, 1'b1, 1'b0);
    n_tests++;
    if (out_valid !== 1'b0) begin n_fail++; $display("FAIL bp_only_first: got v=%b want 0", out_valid); end
  endtask

  task automatic test_grant_capture();
    apply_reset();
    set_word(0, 17'h1F0F0, 24'h0000AA);
    cycle(4'b0001, 1'b1, 1'b0);
    set_word(0, 17'h00001, 24'h0000BB);
    cycle(4'b0001, 1'b1, 1'b0);
    n_tests++;
    if (out_valid !== 1'b1 || out_data !== 17'h1F0F0) begin
      n_fail++; $display("FAIL gc_old: got v=%b data=%h want v=1 data=1f0f0", out_valid, out_data);
    end
    cycle('0, 1'b1, 1'b0);
    n_tests++;
    if (out_valid !== 1'b1 || out_sensor_id !== 2'd0 || out_data !== 17'h00001 || out_timestamp !== 24'h0000BB) begin
      n_fail++; $display("FAIL gc_new: got v=%b id=%0d data=%h ts=%h want v=1 id=0 data=00001 ts=0000bb",
                         out_valid, out_sensor_id, out_data, out_timestamp);
    end
    n_tests++;
    if (cnt_of(0) !== 8'd0 || drop_sticky !== 4'b0000) begin
      n_fail++; $display("FAIL gc_nodrop: got cnt0=%0d sticky=%b want 0", cnt_of(0), drop_sticky);
    end
  endtask

  task automatic test_saturation();
    apply_reset();
    cycle(4'b1000, 1'b0, 1'b0);
    cycle('0, 1'b0, 1'b0);
    cycle(4'b1000, 1'b0, 1'b0);
    for (int k = 0; k < 300; k++) cycle(4'b1000, 1'b0, 1'b0);
    n_tests++;
    if (cnt_of(3) !== 8'd255 || drop_sticky !== 4'b1000) begin
      n_fail++; $display("FAIL sat_cnt3: got cnt3=%0d sticky=%b want 255 1000", cnt_of(3), drop_sticky);
    end
    n_tests++;
    if (drop_count[3*CW-1:0] !== '0) begin
      n_fail++; $display("FAIL sat_others: got %h want 0", drop_count[3*CW-1:0]);
    end
  endtask

  task automatic test_reset_midstream();
    apply_reset();
    cycle(4'b1111, 1'b0, 1'b0);
    cycle('0, 1'b0, 1'b0);
    cycle(4'b0010, 1'b0, 1'b0);
    n_tests++;
    if (out_valid !== 1'b1 || cnt_of(1) !== 8'd1) begin
      n_fail++; $display("FAIL mid_setup: got v=%b cnt1=%0d want v=1 cnt1=1", out_valid, cnt_of(1));
    end
    cycle('0, 1'b0, 1'b1);
    n_tests++;
    if (out_valid !== 1'b0 || drop_count !== '0 || drop_sticky !== '0) begin
      n_fail++; $display("FAIL mid_reset: got v=%b cnt=%h sticky=%b want 0", out_valid, drop_count, drop_sticky);
    end
    cycle('0, 1'b1, 1'b0);
    n_tests++;
    if (out_valid !== 1'b0) begin n_fail++; $display("FAIL mid_slots_empty: got v=%b want 0", out_valid); end
    cycle(4'b1001, 1'b1, 1'b0);
    cycle('0, 1'b1, 1'b0);
    n_tests++;
    if (out_valid !== 1'b1 || out_sensor_id !== 2'd0) begin
      n_fail++; $display("FAIL mid_ptr0: got v=%b id=%0d want v=1 id=0", out_valid, out_sensor_id);
    end
  endtask

  task automatic test_random();
    logic [NS-1:0] s;
    logic rdy;
    apply_reset();
    for (int c = 0; c < 600; c++) begin
      s = '0;
      for (int i = 0; i < NS; i++) begin
        s[i] = ($urandom_range(0, 99) < 35);
        set_word(i, DW'($urandom), TW'($urandom));
      end
      rdy = ($urandom_range(0, 99) < ((c / 100) % 2 == 0 ? 80 : 25));
      cycle(s, rdy, 1'b0);
      n_tests++;
      if (out_valid !== 1'(m_ov)) begin
        n_fail++; $display("FAIL rnd_valid c=%0d: got %b want %0d", c, out_valid, m_ov);
      end
      n_tests++;
      if (out_sensor_id !== IW'(m_id) || out_data !== DW'(m_od) || out_timestamp !== TW'(m_ots)) begin
        n_fail++; $display("FAIL rnd_word c=%0d: got id=%0d data=%h ts=%h want id=%0d data=%h ts=%h",
                           c, out_sensor_id, out_data, out_timestamp, m_id, DW'(m_od), TW'(m_ots));
      end
      for (int i = 0; i < NS; i++) begin
        n_tests++;
        if (cnt_of(i) !== CW'(m_cnt[i]) || drop_sticky[i] !== 1'(m_sticky[i])) begin
          n_fail++; $display("FAIL rnd_drop c=%0d rx%0d: got cnt=%0d sticky=%b want cnt=%0d sticky=%0d",
                             c, i, cnt_of(i), drop_sticky[i], m_cnt[i], m_sticky[i]);
        end
      end
    end
  endtask

  initial begin
    for (int i = 0; i < NS; i++) begin
      m_full[i] = 0; m_data[i] = 0; m_ts[i] = 0; m_cnt[i] = 0; m_sticky[i] = 0;
    end
    m_ptr = 0; m_ov = 0; m_id = 0; m_od = 0; m_ots = 0;
    @(posedge clk);
    #1;
    test_reset();
    test_single_word();
    test_fairness();
    test_backpressure();
    test_grant_capture();
    test_saturation();
    test_reset_midstream();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
